// File: rtl/iter_multiplier.sv
// iter_multiplier: iterative signed shift-add multiplier, responder side of the
// mult_begin/mult_end handshake. Magnitudes are multiplied unsigned over WIDTH
// iterations and the sign is applied on completion.
// Optional macro ITER_MULT_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero (same results, shorter latency).
module iter_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mult_begin,
  input  logic [WIDTH-1:0]     mult_op1,
  input  logic [WIDTH-1:0]     mult_op2,
  output logic [2*WIDTH-1:0]   product,
  output logic                 mult_end,
  output logic                 mult_busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 end_q, end_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     op1_abs, op2_abs;
  logic [WIDTH-1:0]     mplier_nxt;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic                 iter_done;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
  always_comb begin
    op1_abs    = mult_op1[WIDTH-1] ? -mult_op1 : mult_op1;
    op2_abs    = mult_op2[WIDTH-1] ? -mult_op2 : mult_op2;
    mplier_nxt = mplier_q >> 1;
    acc_nxt    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef ITER_MULT_EARLY_TERM_EN
    iter_done  = (cnt_q == CW'(WIDTH - 1)) || (mplier_nxt == '0);
`else
    iter_done  = (cnt_q == CW'(WIDTH - 1));
`endif
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; releasing mult_begin aborts BUSY even on its last iteration
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mult_begin) state_d = BUSY;
      BUSY: begin
        if (!mult_begin)    state_d = IDLE;
        else if (iter_done) state_d = DONE;
      end
      DONE: if (!mult_begin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    end_d     = end_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        end_d = 1'b0;
        if (mult_begin) begin
          mcand_d  = {{WIDTH{1'b0}}, op1_abs};
          mplier_d = op2_abs;
          sign_d   = mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end
      end
      BUSY: begin
        if (!mult_begin) begin
          busy_d = 1'b0;
          end_d  = 1'b0;
        end else begin
          acc_d    = acc_nxt;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_nxt;
          cnt_d    = cnt_q + CW'(1);
          if (iter_done) begin
            product_d = sign_q ? -acc_nxt : acc_nxt;
            end_d     = 1'b1;
            busy_d    = 1'b0;
          end
        end
      end
      DONE: begin
        if (!mult_begin) end_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
        end_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      end_q     <= end_d;
      busy_q    <= busy_d;
    end
  end

  assign product   = product_q;
  assign mult_end  = end_q;
  assign mult_busy = busy_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier (WIDTH = 32): directed and random
// operands compared against signed 64-bit arithmetic and a latency model.
module tb_iter_multiplier;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          mult_begin = 1'b0;
  logic [W-1:0]  mult_op1 = '0;
  logic [W-1:0]  mult_op2 = '0;
  logic [2*W-1:0] product;
  logic          mult_end;
  logic          mult_busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] last_prod = '0;

  iter_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mult_begin(mult_begin),
    .mult_op1  (mult_op1),
    .mult_op2  (mult_op2),
    .product   (product),
    .mult_end  (mult_end),
    .mult_busy (mult_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic longint model_product(input logic [W-1:0] a, input logic [W-1:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic int unsigned model_latency(input logic [W-1:0] b);
`ifdef ITER_MULT_EARLY_TERM_EN
    longint mag;
    int unsigned lat;
    mag = longint'($signed(b));
    if (mag < 0) mag = -mag;
    lat = 1;
    for (int i = 0; i <= W; i++)
      if (((mag >> i) & 64'd1) != 0) lat = i + 1;
    return lat;
`else
    return W;
`endif
  endfunction

  // Start an operation and wait for completion; leaves mult_begin high in DONE
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] exp_p;
    int unsigned lat;
    exp_p = model_product(a, b);
    @(negedge clk);
    mult_op1 = a; mult_op2 = b; mult_begin = 1'b1;
    @(posedge clk); #1;
    check("start_busy", 64'(mult_busy), 64'd1);
    check("start_end", 64'(mult_end), 64'd0);
    lat = 0;
    for (int n = 1; n <= W + 8; n++) begin
      @(posedge clk); #1;
      if (mult_end) begin lat = n; break; end
    end
    check("latency", 64'(lat), 64'(model_latency(b)));
    check("product", product, exp_p);
    check("done_busy", 64'(mult_busy), 64'd0);
    last_prod = exp_p;
  endtask

  task automatic release_op();
    @(negedge clk);
    mult_begin = 1'b0;
    @(posedge clk); #1;
    check("release_end", 64'(mult_end), 64'd0);
    check("release_prod", product, last_prod);
  endtask

  initial begin
    logic [W-1:0] dir_a [8];
    logic [W-1:0] dir_b [8];
    logic seen;

    #1;
    check("rst_prod", product, 64'd0);
    check("rst_end", 64'(mult_end), 64'd0);
    check("rst_busy", 64'(mult_busy), 64'd0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);

    // 3 x 5 then hold begin in DONE while operands wander
    do_op(32'd3, 32'd5);
    check("p_3x5", product, 64'h0000_0000_0000_000F);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      mult_op1 = $urandom; mult_op2 = $urandom;
      if (mult_busy || !mult_end) seen = 1'b1;
    end
    @(negedge clk);
    check("hold_no_restart", 64'(seen), 64'd0);
    check("hold_prod", product, 64'h0000_0000_0000_000F);
    release_op();

    // Abort after 10 iterations: no completion, previous product kept
    @(negedge clk);
    mult_op1 = 32'd1234; mult_op2 = 32'd5678; mult_begin = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk); mult_begin = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(mult_busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < W + 5; i++) begin
      @(posedge clk); #1;
      if (mult_end || mult_busy) seen = 1'b1;
    end
    check("abort_no_end", 64'(seen), 64'd0);
    check("abort_prod", product, 64'h0000_0000_0000_000F);

    // Directed boundary operands
    dir_a = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
              32'd123, 32'd9, 32'h7FFF_FFFF, 32'd0};
    dir_b = '{32'd6, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
              32'd0, 32'd4, 32'h8000_0000, 32'hDEAD_BEEF};
    for (int i = 0; i < 8; i++) begin
      do_op(dir_a[i], dir_b[i]);
      release_op();
    end
    do_op(32'hFFFF_FFF9, 32'd6);
    check("p_m7x6", product, 64'hFFFF_FFFF_FFFF_FFD6);
    release_op();
    do_op(32'h8000_0000, 32'h8000_0000);
    check("p_min_sq", product, 64'h4000_0000_0000_0000);
    release_op();
    do_op(32'h8000_0000, 32'd1);
    check("p_min_x1", product, 64'hFFFF_FFFF_8000_0000);
    release_op();

    // Random operands
    for (int i = 0; i < 20; i++) begin
      do_op($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom);
      release_op();
    end

    // Asynchronous reset mid-BUSY, away from a clock edge
    @(negedge clk);
    mult_op1 = 32'd77; mult_op2 = 32'd99; mult_begin = 1'b1;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_prod", product, 64'd0);
    check("arst_end", 64'(mult_end), 64'd0);
    check("arst_busy", 64'(mult_busy), 64'd0);
    @(negedge clk); mult_begin = 1'b0; resetn = 1'b1;
    @(negedge clk);
    last_prod = '0;
    do_op(32'hFFFF_FFFE, 32'd21);
    release_op();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iter_multiplier.md
Name: iter_multiplier

Overview:
- Iterative signed shift-add multiplier; the responder side of the mult_begin/mult_end handshake used by the board display wrappers.
- Handshake rules:
  - The initiator drives operands and holds mult_begin high (typically from a switch).
  - This block computes the product over multiple cycles, then holds mult_end high with a stable product until mult_begin is released.
- Sits between the display/IO wrapper and nothing else; it has no memory or bus interface.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; WIDTH >= 4.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset, asynchronous, active-low.
- mult_begin  input  1  level request; high = start/hold operation, low = release/abort.
- mult_op1  input  WIDTH  multiplicand, two's complement; sampled only on the start edge.
- mult_op2  input  WIDTH  multiplier, two's complement; sampled only on the start edge.
- product  output  2*WIDTH  signed result of the last completed operation.
- mult_end  output  1  high while the result is valid and mult_begin is still high.
- mult_busy  output  1  high while iterating.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (resetn).
- Reset values: state=IDLE, product=0, mult_end=0, mult_busy=0, internal registers 0.
- States: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - mult_begin=1 at edge k:
    - Latch |op1| into a 2*WIDTH multiplicand register (zero-extended).
    - Latch |op2| into a WIDTH multiplier shift register.
    - Store sign = op1[WIDTH-1]^op2[WIDTH-1].
    - Clear the accumulator and the iteration counter.
    - Go to BUSY; mult_busy=1.
  - mult_begin=0: stay in IDLE.
- BUSY, one iteration per edge:
  - If multiplier[0]=1, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1.
  - Increment the counter.
  - On the iteration that makes counter == WIDTH:
    - product <= sign ? -(acc_next) : acc_next, computed mod 2^(2*WIDTH).
    - mult_end=1, mult_busy=0, go to DONE.
  - Fixed latency: mult_end first high after edge k+WIDTH (k = start edge).
- Absolute value of the most negative operand (-2^(WIDTH-1)):
  - Treated as the unsigned magnitude 2^(WIDTH-1); no overflow.
  - Full 2*WIDTH result is always exact.
- DONE:
  - product is stable, mult_end=1.
  - Holding mult_begin high does NOT restart the operation.
  - mult_begin=0: mult_end<=0 at the next edge, go to IDLE; product keeps its value.
  - A new operation needs mult_begin low for at least 1 cycle, then high again.
- Abort: mult_begin=0 during BUSY:
  - Go to IDLE at the next edge, mult_busy<=0.
  - mult_end stays 0; product keeps the previous completed result.
- Operand changes while BUSY or DONE are ignored.
- Reset asserted mid-operation: immediate return to reset values, including product=0.
- Product register is written only on completion.

Optional Feature:
- Macro: ITER_MULT_EARLY_TERM_EN.
- Defined (early termination):
  - BUSY also completes when the shifted-multiplier value after the current iteration is 0.
  - Latency becomes 1 + index of the highest set bit of |op2|; minimum 1 (op2=0 → mult_end after edge k+1).
  - Results are identical to the undefined case.
- Undefined: fixed WIDTH-iteration latency; no zero-detect logic.

Test Plan:
- 3 × 5, begin held → mult_end rises after exactly 32 iteration edges; product=0x0000_0000_0000_000F; mult_busy low in DONE.
- -7 (0xFFFF_FFF9) × 6 → product=0xFFFF_FFFF_FFFF_FFD6; 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0000_0000_0001.
- 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000; 0x8000_0000 × 1 → 0xFFFF_FFFF_8000_0000.
- Hold begin 100 cycles after DONE while changing operands → product unchanged, no restart.
- Drop begin → mult_end low next edge; re-raise begin → new result.
- Drop begin at iteration 10 → IDLE, mult_end never asserts, product keeps prior 0x...0F.
- Assert resetn=0 mid-BUSY without a clock edge → outputs 0 immediately.
- With ITER_MULT_EARLY_TERM_EN:
  - 123 × 0 → mult_end after edge k+1, product=0.
  - 9 × 4 → done after 3 iterations, product=36.
  - Without the macro, both take 32 iterations.
